attention_score_reader: RTL and testbench
=========================================

# attention_score_reader

Read-side initiator for the attention-score C SRAM port. After a GEMM completes, it sweeps all T×T score entries in row-major order by issuing `score_re` requests and collecting in-order `score_rvalid` responses. Results go through a credit-limited FIFO and leave as a valid/ready stream tagged with coordinates. It sits between the attention-score GEMM wrapper and the downstream softmax/normalisation stage.

## Interface
- `T`, 8: score matrix dimension (T×T entries); T_W = (T<=1) ? 1 : $clog2(T)
- `DATA_W`, 32: score word width
- `FIFO_DEPTH`, 4: output buffer depth and maximum outstanding requests; power of two, ≥2
- `TIMEOUT`, 64: cycles without `score_rvalid` while requests are outstanding before abort; ≥2

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse; begins a sweep, sampled only in IDLE
- `busy`  out  1  high in RUN/DRAIN
- `done`  out  1  one-cycle pulse at normal completion
- `err_timeout`  out  1  sticky abort flag, cleared by the next accepted `start` or by reset
- `score_re`  out  1  one-cycle read request
- `score_tq`  out  T_W  request row
- `score_tk`  out  T_W  request column
- `score_rdata`  in  DATA_W  response data
- `score_rvalid`  in  1  response strobe; responses arrive in request order, latency ≥1 cycle
- `out_valid`  out  1  stream data valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  DATA_W  score value
- `out_tq`, `out_tk`  out  T_W  coordinates of `out_data`
- `out_last`  out  1  high with entry (T-1,T-1)

## Operation
- States: IDLE, RUN, DRAIN, DONE, ERR.
- **IDLE**
  - `start` clears `err_timeout`, zeroes the issue counter (iq, ik), the response counter (rq, rk), `outstanding` and the FIFO, then moves to RUN.
  - `start` in any other state is ignored.
- **RUN** issue rule:
  - Assert `score_re` with `score_tq`=iq and `score_tk`=ik when `fifo_count + outstanding < FIFO_DEPTH`, using registered values.
  - On issue, increment ik; when ik wraps from T-1 to 0, increment iq.
  - Also on issue, increment `outstanding` unless a response arrives the same cycle, in which case it holds.
  - After issuing (T-1,T-1), move to DRAIN.
- **Response path** (RUN/DRAIN):
  - On `score_rvalid` with `outstanding`>0, push {rdata, rq, rk, last=(rq==T-1 && rk==T-1)}, decrement `outstanding`, and advance (rq, rk) row-major.
  - `score_rvalid` with `outstanding`==0, or in IDLE/DONE/ERR, is ignored.
- **Output**
  - FIFO head drives `out_*`; a pop occurs on `out_valid && out_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - The credit rule makes overflow impossible.
- **DRAIN → DONE**: taken when a pop with last=1 occurs. DONE asserts `done` for one cycle, then returns to IDLE.
- **Timeout**
  - A counter increments each cycle that `outstanding`>0 and `score_rvalid`=0, and clears otherwise.
  - Reaching TIMEOUT-1 sends the block to ERR: set `err_timeout`, flush the FIFO, zero `outstanding`, no `done` pulse.
  - ERR returns to IDLE the next cycle.
- `out_ready` low does not block issue beyond the credit limit.
- When T=1 the single request goes directly RUN→DRAIN.

## Timing
- Reset values: `busy`, `done`, `err_timeout`, `score_re`, `out_valid`, `out_last` = 0; `score_tq`, `score_tk`, `out_data`, `out_tq`, `out_tk` = 0.
- Reset mid-sweep flushes all state. Responses arriving after reset are ignored because `outstanding`=0.
- `start` in cycle 0 gives RUN in cycle 1 and the first `score_re` in cycle 1.
- Back-to-back `score_re` every cycle while credits allow.
- FIFO is registered: data pushed on an rvalid in cycle N is visible on `out_valid` in cycle N+1.
- With latency L=1, FIFO_DEPTH=4, and `out_ready` held high:
  - one entry is emitted per cycle after fill;
  - last pop occurs in cycle T·T+2;
  - `done` pulses in cycle T·T+3.
- `busy` is high in the cycle after `start` through the last-pop cycle; it is low in DONE.

## Test plan
- T=4, L=1, `out_ready`=1, score[q][k]=16q+k → 16 outputs in row-major order, values 0x00..0x33, `out_last` only on (3,3), one `done` pulse, `err_timeout`=0.
- L=3, `out_ready` held 0 for 20 cycles → issue stops after 4 requests. `outstanding`+`fifo_count` never exceeds 4. Releasing `out_ready` completes the stream with no loss or duplication.
- Random `out_ready` (50%) and random latency 1–4 (in-order) → the output sequence matches the reference matrix exactly; `done` pulses once.
- Responder stops after 5 responses, TIMEOUT=16 → `err_timeout`=1 sixteen cycles after the last rvalid, no `done`. The next `start` clears `err_timeout` and a full sweep succeeds.
- `rst` asserted mid-sweep, then a stale `score_rvalid` the cycle after release → all outputs 0, stale response ignored, a new `start` yields a correct 16-entry stream.
- `start` pulsed during RUN, and spurious `score_rvalid` in IDLE → both ignored, no extra outputs.

Source files
------------

// File: rtl/attention_score_reader.sv
// -----------------------------------------------------------------------------
// attention_score_reader
//
// Read-side initiator for the attention-score C SRAM port. After a GEMM
// completes, a start pulse launches a row-major sweep over all T x T score
// entries. Requests are credit limited so that every outstanding read always
// has a guaranteed slot in the output FIFO. In-order responses are tagged with
// their (row, column) coordinates and leave as a valid/ready stream.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               single-cycle pulse, honoured only in IDLE
//   busy                high while sweeping (RUN / DRAIN)
//   done                one-cycle pulse on normal completion
//   err_timeout         sticky abort flag, cleared by the next accepted start
//   score_re            one-cycle read request
//   score_tq, score_tk  request row / column
//   score_rdata         response data
//   score_rvalid        response strobe, in request order
//   out_valid/out_ready stream handshake
//   out_data            score value
//   out_tq, out_tk      coordinates of out_data
//   out_last            marks entry (T-1, T-1)
// -----------------------------------------------------------------------------
module attention_score_reader #(
    parameter int T          = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    localparam int T_W       = (T <= 1) ? 1 : $clog2(T)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              score_re,
    output logic [T_W-1:0]    score_tq,
    output logic [T_W-1:0]    score_tk,
    input  logic [DATA_W-1:0] score_rdata,
    input  logic              score_rvalid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [T_W-1:0]    out_tq,
    output logic [T_W-1:0]    out_tk,
    output logic              out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    localparam logic [T_W-1:0]   LAST_IDX = T_W'(T - 1);
    localparam logic [SUM_W-1:0] DEPTH_C  = SUM_W'(FIFO_DEPTH);
    // The counter is compared one step early so the abort lands on the edge
    // where the stall count would reach TIMEOUT-1.
    localparam logic [TO_W-1:0]  TO_TRIP  = TO_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t             state_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic [T_W-1:0]     iq_r;
    logic [T_W-1:0]     ik_r;
    logic [T_W-1:0]     rq_r;
    logic [T_W-1:0]     rk_r;
    logic [CNT_W-1:0]   outstanding_r;
    logic [TO_W-1:0]    tcnt_r;

    logic [DATA_W-1:0]  mem_data_r [FIFO_DEPTH];
    logic [T_W-1:0]     mem_tq_r   [FIFO_DEPTH];
    logic [T_W-1:0]     mem_tk_r   [FIFO_DEPTH];
    logic               mem_last_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   fifo_count_r;

    logic               active_s;
    logic [SUM_W-1:0]   credit_sum_s;
    logic               issue_s;
    logic               resp_s;
    logic               head_valid_s;
    logic               pop_s;
    logic               last_pop_s;
    logic               stall_s;
    logic               timeout_s;
    logic               accept_start_s;
    logic               flush_s;

    // Datapath decode, all derived from registered state.
    assign active_s       = (state_r == S_RUN) || (state_r == S_DRAIN);
    // FIFO slots already taken plus slots reserved for in-flight reads.
    assign credit_sum_s   = SUM_W'(fifo_count_r) + SUM_W'(outstanding_r);
    assign issue_s        = (state_r == S_RUN) && (credit_sum_s < DEPTH_C);
    assign resp_s         = active_s && score_rvalid && (outstanding_r != '0);
    assign head_valid_s   = (fifo_count_r != '0);
    assign pop_s          = head_valid_s && out_ready;
    assign last_pop_s     = pop_s && mem_last_r[rd_ptr_r];
    assign stall_s        = (outstanding_r != '0) && !score_rvalid;
    assign timeout_s      = active_s && stall_s && (tcnt_r == TO_TRIP);
    assign accept_start_s = (state_r == S_IDLE) && start;
    assign flush_s        = accept_start_s || timeout_s;

    assign busy        = busy_r;
    assign done        = done_r;
    assign err_timeout = err_r;
    assign score_re    = issue_s;
    assign score_tq    = iq_r;
    assign score_tk    = ik_r;
    assign out_valid   = head_valid_s;
    assign out_data    = mem_data_r[rd_ptr_r];
    assign out_tq      = mem_tq_r[rd_ptr_r];
    assign out_tk      = mem_tk_r[rd_ptr_r];
    assign out_last    = head_valid_s && mem_last_r[rd_ptr_r];

    // Sweep FSM: issue/response counters, credit tracking, timeout and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            iq_r          <= '0;
            ik_r          <= '0;
            rq_r          <= '0;
            rk_r          <= '0;
            outstanding_r <= '0;
            tcnt_r        <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r       <= S_RUN;
                        busy_r        <= 1'b1;
                        err_r         <= 1'b0;
                        iq_r          <= '0;
                        ik_r          <= '0;
                        rq_r          <= '0;
                        rk_r          <= '0;
                        outstanding_r <= '0;
                        tcnt_r        <= '0;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (issue_s) begin
                        if (ik_r == LAST_IDX) begin
                            ik_r <= '0;
                            iq_r <= (iq_r == LAST_IDX) ? '0 : iq_r + T_W'(1);
                        end else begin
                            ik_r <= ik_r + T_W'(1);
                        end
                    end
                    if (resp_s) begin
                        if (rk_r == LAST_IDX) begin
                            rk_r <= '0;
                            rq_r <= (rq_r == LAST_IDX) ? '0 : rq_r + T_W'(1);
                        end else begin
                            rk_r <= rk_r + T_W'(1);
                        end
                    end
                    // A response in the issue cycle hands its credit straight over.
                    if (issue_s && !resp_s) begin
                        outstanding_r <= outstanding_r + CNT_W'(1);
                    end else if (resp_s && !issue_s) begin
                        outstanding_r <= outstanding_r - CNT_W'(1);
                    end else begin
                        outstanding_r <= outstanding_r;
                    end
                    if (stall_s) begin
                        tcnt_r <= tcnt_r + TO_W'(1);
                    end else begin
                        tcnt_r <= '0;
                    end

                    if (timeout_s) begin
                        state_r       <= S_ERR;
                        busy_r        <= 1'b0;
                        err_r         <= 1'b1;
                        outstanding_r <= '0;
                        tcnt_r        <= '0;
                    end else if ((state_r == S_RUN) && issue_s &&
                                 (iq_r == LAST_IDX) && (ik_r == LAST_IDX)) begin
                        state_r <= S_DRAIN;
                    end else if ((state_r == S_DRAIN) && last_pop_s) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                S_ERR: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output FIFO: push tagged responses, pop on handshake, flush on start/abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_r[i] <= '0;
                mem_tq_r[i]   <= '0;
                mem_tk_r[i]   <= '0;
                mem_last_r[i] <= 1'b0;
            end
        end else if (flush_s) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
        end else begin
            if (resp_s) begin
                mem_data_r[wr_ptr_r] <= score_rdata;
                mem_tq_r[wr_ptr_r]   <= rq_r;
                mem_tk_r[wr_ptr_r]   <= rk_r;
                mem_last_r[wr_ptr_r] <= (rq_r == LAST_IDX) && (rk_r == LAST_IDX);
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (resp_s && !pop_s) begin
                fifo_count_r <= fifo_count_r + CNT_W'(1);
            end else if (pop_s && !resp_s) begin
                fifo_count_r <= fifo_count_r - CNT_W'(1);
            end else begin
                fifo_count_r <= fifo_count_r;
            end
        end
    end

endmodule

// File: tb/tb_attention_score_reader.sv
// -----------------------------------------------------------------------------
// tb_attention_score_reader
//
// Self-checking bench for attention_score_reader (T=4, FIFO_DEPTH=4,
// TIMEOUT=16). An in-order SRAM responder with configurable latency answers
// requests from a score matrix; the expected stream is every matrix entry in
// row-major order with out_last only on the final one. All activity is driven
// and observed on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_attention_score_reader;

    localparam int T       = 4;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TO      = 16;
    localparam int T_W     = 2;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                q;
        int                k;
        logic              last;
    } ent_t;

    typedef struct {
        int due;
        int q;
        int k;
    } req_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic              score_re;
    logic [T_W-1:0]    score_tq;
    logic [T_W-1:0]    score_tk;
    logic [DATA_W-1:0] score_rdata;
    logic              score_rvalid;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [T_W-1:0]    out_tq;
    logic [T_W-1:0]    out_tk;
    logic              out_last;

    attention_score_reader #(
        .T          (T),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .score_re     (score_re),
        .score_tq     (score_tq),
        .score_tk     (score_tk),
        .score_rdata  (score_rdata),
        .score_rvalid (score_rvalid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tq       (out_tq),
        .out_tk       (out_tk),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    // reference matrix and observation state
    logic [DATA_W-1:0] mat [T][T];
    ent_t got [$];
    req_t req_q [$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    int   lat_min = 1;
    int   lat_max = 1;
    int   resp_left = -1;
    logic stray = 1'b0;
    int   last_due, issued, popped, max_inflight, done_cnt, done_cyc;
    int   err_cyc, first_re_cyc, last_pop_cyc, last_rv_cyc, issued_at_release;
    int   valid_seen;
    logic busy_at_last_pop, busy_at_done;

    task automatic fill_matrix(input bit pattern);
        for (int q = 0; q < T; q++)
            for (int k = 0; k < T; k++)
                mat[q][k] = pattern ? DATA_W'(16 * q + k) : DATA_W'($urandom());
    endtask

    // first index where the observed stream departs from row-major order, -1 if none
    function automatic int first_bad();
        int n;
        n = T * T;
        for (int i = 0; i < n; i++) begin
            if (i >= got.size()) return i;
            if (got[i].data !== mat[i / T][i % T] || got[i].q != i / T ||
                got[i].k != i % T || got[i].last !== (i == n - 1))
                return i;
        end
        if (got.size() != n) return n;
        return -1;
    endfunction

    // one clock cycle: drive inputs, run the responder, record outputs
    task automatic step();
        int   lat;
        int   due;
        req_t r;
        ent_t e;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(1, 0));
        endcase
        if (score_re === 1'b1) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due = due;
            r.q   = int'(score_tq);
            r.k   = int'(score_tk);
            req_q.push_back(r);
            issued++;
            if (first_re_cyc < 0) first_re_cyc = cyc;
        end
        score_rvalid = 1'b0;
        score_rdata  = DATA_W'($urandom());
        if (stray) begin
            score_rvalid = 1'b1;
            score_rdata  = 32'hDEAD_BEEF;
        end else if (req_q.size() > 0 && resp_left != 0 && req_q[0].due <= cyc) begin
            r = req_q.pop_front();
            score_rvalid = 1'b1;
            score_rdata  = mat[r.q][r.k];
            if (resp_left > 0) resp_left--;
            last_rv_cyc = cyc;
        end
        if (out_valid === 1'b1) valid_seen++;
        if (out_valid === 1'b1 && out_ready) begin
            e.data = out_data;
            e.q    = int'(out_tq);
            e.k    = int'(out_tk);
            e.last = out_last;
            got.push_back(e);
            popped++;
            last_pop_cyc     = cyc;
            busy_at_last_pop = busy;
        end
        if (issued - popped > max_inflight) max_inflight = issued - popped;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        if (err_timeout === 1'b1 && err_cyc < 0) err_cyc = cyc;
    endtask

    // pulse start (cycle 0), run until done/abort or the cycle budget, then settle
    task automatic run_sweep(input int max_cyc, input int restart_at, input int release_at);
        got.delete();
        req_q.delete();
        issued = 0; popped = 0; max_inflight = 0; done_cnt = 0; done_cyc = -1;
        err_cyc = -1; first_re_cyc = -1; last_pop_cyc = -1; last_rv_cyc = -1;
        issued_at_release = -1; last_due = 0;
        busy_at_last_pop = 1'b0; busy_at_done = 1'bx;
        cyc = 0;
        start = 1'b1;
        while (done_cnt == 0 && err_cyc < 0 && cyc < max_cyc) begin
            step();
            if (cyc == restart_at) start = 1'b1;
            if (cyc == release_at) begin
                issued_at_release = issued;
                ready_mode = 0;
            end
        end
        repeat (6) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({busy, done, err_timeout, score_re, out_valid, out_last,
             score_tq, score_tk, out_data, out_tq, out_tk} !== 46'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {busy, done, err_timeout, score_re, out_valid, out_last,
                      score_tq, score_tk, out_data, out_tq, out_tk});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int bad;
        fill_matrix(1'b1);
        ready_mode = 0; lat_min = 1; lat_max = 1; resp_left = -1;
        run_sweep(100, -1, -1);
        bad = first_bad();
        n_cmp++;
        if (bad !== -1) begin
            n_bad++;
            $display("FAIL basic_stream: first bad index %0d, got %0d entries required %0d", bad, got.size(), T * T);
        end
        n_cmp++;
        if (first_re_cyc !== 1) begin n_bad++; $display("FAIL basic_first_re: got cycle %0d required 1", first_re_cyc); end
        n_cmp++;
        if (last_pop_cyc !== T * T + 2) begin n_bad++; $display("FAIL basic_last_pop: got cycle %0d required %0d", last_pop_cyc, T * T + 2); end
        n_cmp++;
        if (done_cyc !== T * T + 3) begin n_bad++; $display("FAIL basic_done_cycle: got %0d required %0d", done_cyc, T * T + 3); end
        n_cmp++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d required 1", done_cnt); end
        n_cmp++;
        if (busy_at_last_pop !== 1'b1) begin n_bad++; $display("FAIL basic_busy_last_pop: got %b required 1", busy_at_last_pop); end
        n_cmp++;
        if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b required 0", busy_at_done); end
        n_cmp++;
        if (err_cyc !== -1) begin n_bad++; $display("FAIL basic_err: err_timeout seen at cycle %0d required never", err_cyc); end
    endtask

    task automatic test_backpressure();
        int bad;
        fill_matrix(1'b0);
        ready_mode = 1; lat_min = 3; lat_max = 3; resp_left = -1;
        run_sweep(300, -1, 20);
        n_cmp++;
        if (issued_at_release !== DEPTH) begin n_bad++; $display("FAIL bp_issue_stop: got %0d requests required %0d", issued_at_release, DEPTH); end
        n_cmp++;
        if (max_inflight > DEPTH) begin n_bad++; $display("FAIL bp_credit: got %0d in flight required <= %0d", max_inflight, DEPTH); end
        bad = first_bad();
        n_cmp++;
        if (bad !== -1) begin n_bad++; $display("FAIL bp_stream: first bad index %0d, got %0d entries required %0d", bad, got.size(), T * T); end
        n_cmp++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL bp_done_count: got %0d required 1", done_cnt); end
    endtask

    task automatic test_random();
        int bad;
        for (int it = 0; it < 3; it++) begin
            fill_matrix(1'b0);
            ready_mode = 2; lat_min = 1; lat_max = 4; resp_left = -1;
            run_sweep(600, -1, -1);
            bad = first_bad();
            n_cmp++;
            if (bad !== -1) begin n_bad++; $display("FAIL rand_stream[%0d]: first bad index %0d, got %0d entries required %0d", it, bad, got.size(), T * T); end
            n_cmp++;
            if (done_cnt !== 1) begin n_bad++; $display("FAIL rand_done_count[%0d]: got %0d required 1", it, done_cnt); end
            n_cmp++;
            if (max_inflight > DEPTH) begin n_bad++; $display("FAIL rand_credit[%0d]: got %0d in flight required <= %0d", it, max_inflight, DEPTH); end
            n_cmp++;
            if (err_cyc !== -1) begin n_bad++; $display("FAIL rand_err[%0d]: err_timeout seen at cycle %0d required never", it, err_cyc); end
        end
    endtask

    task automatic test_timeout();
        int bad;
        fill_matrix(1'b0);
        ready_mode = 0; lat_min = 1; lat_max = 1; resp_left = 5;
        run_sweep(200, -1, -1);
        n_cmp++;
        if (err_cyc < 0 || err_cyc - last_rv_cyc !== TO) begin
            n_bad++;
            $display("FAIL to_delay: got err at cycle %0d, last rvalid %0d, required delay %0d", err_cyc, last_rv_cyc, TO);
        end
        n_cmp++;
        if (done_cnt !== 0) begin n_bad++; $display("FAIL to_no_done: got %0d done pulses required 0", done_cnt); end
        n_cmp++;
        if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b required 1", err_timeout); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL to_busy: got %b required 0", busy); end
        resp_left = -1;
        run_sweep(100, -1, -1);
        bad = first_bad();
        n_cmp++;
        if (bad !== -1) begin n_bad++; $display("FAIL to_recover_stream: first bad index %0d, got %0d entries required %0d", bad, got.size(), T * T); end
        n_cmp++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL to_recover_done: got %0d required 1", done_cnt); end
        n_cmp++;
        if (err_cyc !== -1) begin n_bad++; $display("FAIL to_recover_err: err_timeout seen at cycle %0d required cleared", err_cyc); end
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_matrix(1'b0);
        ready_mode = 0; lat_min = 1; lat_max = 2; resp_left = -1;
        run_sweep(8, -1, -1);
        rst = 1'b1;
        step();
        n_cmp++;
        if ({busy, done, err_timeout, score_re, out_valid, out_last,
             score_tq, score_tk, out_data, out_tq, out_tk} !== 46'd0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got %h required 0",
                     {busy, done, err_timeout, score_re, out_valid, out_last,
                      score_tq, score_tk, out_data, out_tq, out_tk});
        end
        rst = 1'b0;
        req_q.delete();
        valid_seen = 0;
        stray = 1'b1;
        step();
        stray = 1'b0;
        repeat (4) step();
        n_cmp++;
        if (valid_seen !== 0) begin n_bad++; $display("FAIL midrst_stale: got %0d valid cycles required 0", valid_seen); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
        fill_matrix(1'b0);
        run_sweep(100, -1, -1);
        bad = first_bad();
        n_cmp++;
        if (bad !== -1) begin n_bad++; $display("FAIL midrst_stream: first bad index %0d, got %0d entries required %0d", bad, got.size(), T * T); end
        n_cmp++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL midrst_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_spurious();
        int bad;
        fill_matrix(1'b0);
        ready_mode = 0; lat_min = 1; lat_max = 3; resp_left = -1;
        valid_seen = 0;
        stray = 1'b1;
        repeat (3) step();
        stray = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (valid_seen !== 0) begin n_bad++; $display("FAIL spur_idle_rvalid: got %0d valid cycles required 0", valid_seen); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL spur_idle_busy: got %b required 0", busy); end
        run_sweep(100, 5, -1);
        n_cmp++;
        if (issued !== T * T) begin n_bad++; $display("FAIL spur_restart_issue: got %0d requests required %0d", issued, T * T); end
        bad = first_bad();
        n_cmp++;
        if (bad !== -1) begin n_bad++; $display("FAIL spur_stream: first bad index %0d, got %0d entries required %0d", bad, got.size(), T * T); end
        n_cmp++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL spur_done: got %0d required 1", done_cnt); end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        out_ready    = 1'b0;
        score_rvalid = 1'b0;
        score_rdata  = '0;
        valid_seen   = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_timeout();
        test_reset_mid();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
